// File: rtl/npc_lsu_pkg.sv
// Shared types and encodings for the load/store and writeback stage.
// Covers operation kinds, RV32 load/store funct3 codes and FSM state codes.
package npc_lsu_pkg;

   typedef enum logic [1:0] {
      KIND_ALU   = 2'd0,
      KIND_LOAD  = 2'd1,
      KIND_STORE = 2'd2,
      KIND_RSVD  = 2'd3
   } kind_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_WB   = 2'd3;

endpackage

// File: rtl/lsu_wb_if.sv
// Data-memory valid/ready bus between the LSU and the memory.
// The master side is the LSU; the slave side is the memory.
interface lsu_wb_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  mem_req_ready, mem_resp_valid, mem_rdata
   );

   modport slave (
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output mem_req_ready, mem_resp_valid, mem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational legality check, store lane formatting and load extraction.
// The store side sees the incoming op; the load side sees the latched op.
import npc_lsu_pkg::*;

module lsu_align (
   input  kind_e       kind,
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] sdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] rdata,
   output logic        ok,
   output logic [3:0]  wmask,
   output logic [31:0] wdata,
   output logic [31:0] ldata
);

   logic        f3_ok;
   logic        al_ok;
   logic [31:0] sh;

   always_comb begin
      f3_ok = 1'b0;
      case (kind)
         KIND_LOAD:  f3_ok = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
         KIND_STORE: f3_ok = funct3 inside {F3_SB, F3_SH, F3_SW};
         default:    f3_ok = 1'b0;
      endcase
   end

   always_comb begin
      al_ok = 1'b0;
      wmask = 4'b1111;
      wdata = sdata;
      case (funct3[1:0])
         2'b00: begin
            al_ok = 1'b1;
            wmask = 4'b0001 << off;
            wdata = {4{sdata[7:0]}};
         end
         2'b01: begin
            al_ok = ~off[0];
            wmask = 4'b0011 << off;
            wdata = {2{sdata[15:0]}};
         end
         2'b10: al_ok = (off == 2'b00);
         default: al_ok = 1'b0;
      endcase
   end

   assign ok = f3_ok & al_ok;
   assign sh = rdata >> {ld_off, 3'b000};

   always_comb begin
      ldata = rdata;
      case (ld_funct3)
         F3_LB:   ldata = {{24{sh[7]}}, sh[7:0]};
         F3_LH:   ldata = {{16{sh[15]}}, sh[15:0]};
         F3_LBU:  ldata = {24'd0, sh[7:0]};
         F3_LHU:  ldata = {16'd0, sh[15:0]};
         default: ldata = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_wb.sv
// Load/store and writeback stage: one op in flight, memory access over
// a valid/ready bus, and the only source of register-file write traffic.
import npc_lsu_pkg::*;

module lsu_wb #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_kind,
   input  logic [2:0]            in_funct3,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic [DATA_WIDTH-1:0] in_result,
   input  logic [DATA_WIDTH-1:0] in_sdata,
   lsu_wb_if.master              mem,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  retire,
   output logic                  misalign
);

   logic [1:0]            state_q;
   logic                  load_q;
   logic [2:0]            f3_q;
   logic [1:0]            off_q;
   logic                  wr_q;
   logic                  mis_q;
   logic [31:0]           addr_q;
   logic                  wen_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wmask_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic        ok;
   logic [3:0]  st_wmask;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;
   logic        is_mem;

   assign is_mem = (in_kind == KIND_LOAD) || (in_kind == KIND_STORE);

   lsu_align u_align (
      .kind      (kind_e'(in_kind)),
      .funct3    (in_funct3),
      .off       (in_result[1:0]),
      .sdata     (in_sdata),
      .ld_funct3 (f3_q),
      .ld_off    (off_q),
      .rdata     (mem.mem_rdata),
      .ok        (ok),
      .wmask     (st_wmask),
      .wdata     (st_wdata),
      .ldata     (ld_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         load_q  <= 1'b0;
         f3_q    <= '0;
         off_q   <= '0;
         wr_q    <= 1'b0;
         mis_q   <= 1'b0;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         waddr_q <= '0;
         rdata_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: if (in_valid) begin
               load_q  <= (in_kind == KIND_LOAD);
               f3_q    <= in_funct3;
               off_q   <= in_result[1:0];
               waddr_q <= in_rd;
               mis_q   <= 1'b0;
               wr_q    <= 1'b0;
               if (is_mem && ok) begin
                  state_q <= ST_REQ;
                  addr_q  <= {in_result[31:2], 2'b00};
                  wen_q   <= (in_kind == KIND_STORE);
                  wdata_q <= st_wdata;
                  wmask_q <= st_wmask;
               end else if (is_mem) begin
                  state_q <= ST_WB;
                  mis_q   <= 1'b1;
               end else begin
                  // reserved kind retires like ALU but never writes
                  state_q <= ST_WB;
                  wr_q    <= (in_kind == KIND_ALU) && (in_rd != '0);
                  rdata_q <= in_result;
               end
            end
            ST_REQ: if (mem.mem_req_ready) state_q <= ST_WAIT;
            ST_WAIT: if (mem.mem_resp_valid) begin
               if (load_q) begin
                  rdata_q <= ld_data;
                  wr_q    <= (waddr_q != '0);
               end
               state_q <= ST_WB;
            end
            ST_WB: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready          = (state_q == ST_IDLE);
   assign mem.mem_req_valid = (state_q == ST_REQ);
   assign mem.mem_addr      = addr_q;
   assign mem.mem_wen       = wen_q;
   assign mem.mem_wdata     = wdata_q;
   assign mem.mem_wmask     = wmask_q;
   assign retire            = (state_q == ST_WB);
   assign misalign          = retire & mis_q;
   assign rf_wen            = retire & wr_q;
   assign rf_waddr          = waddr_q;
   assign rf_wdata          = rdata_q;

endmodule

// File: doc/lsu_wb.md
# lsu_wb

Load/store and writeback stage of the NPC core. It accepts one retired-execute operation at a time from the execute stage. For memory operations it performs the data-memory transaction over a valid/ready bus, then aligns and extends the load data. It drives the register file's write port (`wen`/`waddr`/`wdata`) for exactly one cycle per register-writing instruction, making it the sole producer of register-file write traffic.

## Interface
Parameters:
- ADDR_WIDTH, 4, register-file address width; must match the register file.
- DATA_WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  execute stage presents an operation.
- in_ready  out  1  stage can accept an operation; high only in IDLE.
- in_kind  in  2  operation kind: 0 = ALU, 1 = LOAD, 2 = STORE, 3 = reserved (treated as ALU with no write).
- in_funct3  in  3  load/store size and sign code (RV32 encoding).
- in_rd  in  ADDR_WIDTH  destination register.
- in_result  in  32  ALU result, or effective address for LOAD/STORE.
- in_sdata  in  32  store source data.
- mem_req_valid  out  1  memory request pending.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  32  word address, `{addr[31:2],2'b00}`.
- mem_wen  out  1  1 = store, 0 = load.
- mem_wdata  out  32  lane-shifted store data.
- mem_wmask  out  4  byte-enable mask.
- mem_resp_valid  in  1  read data valid, or write acknowledge.
- mem_rdata  in  32  read word.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  ADDR_WIDTH  register-file write address.
- rf_wdata  out  32  register-file write data.
- retire  out  1  one-cycle pulse when the operation completes.
- misalign  out  1  one-cycle pulse, coincident with `retire`, for a misaligned or illegal-funct3 access.

## Operation
States:
- IDLE
  - `in_ready` = 1.
  - On `in_valid`: latch kind, funct3, rd, result and sdata.
  - ALU → WB.
  - LOAD/STORE, aligned and legal → REQ.
  - Misaligned or illegal → WB with the write suppressed and the misalign flag set.
- REQ
  - `mem_req_valid` = 1; address, wen, wdata and wmask are held stable.
  - Advance to WAIT on `mem_req_valid && mem_req_ready`.
- WAIT
  - On `mem_resp_valid`: for LOAD, capture aligned/extended data; then → WB.
- WB
  - `retire` = 1.
  - `rf_wen` = 1 for ALU and for successful LOAD, only when rd ≠ 0.
  - `misalign` reflects the latched flag.
  - Next state is IDLE.

Alignment rules, with off = addr[1:0]:
- Byte access: always legal.
- Halfword access: legal when off[0] = 0.
- Word access: legal when off = 0.
- Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010. Any other value is illegal.

Load extraction:
- Select the byte or halfword at off × 8.
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.

Store formatting:
- Byte: mask = 0001 << off, data = byte replicated into all four lanes.
- Halfword: mask = 0011 << off, data = halfword replicated into both halves.
- Word: mask = 1111, data = sdata.

Boundary conditions:
- `mem_resp_valid` in IDLE, REQ or WB is ignored.
- Asserting reset mid-transaction returns the stage to IDLE. A late response then arrives in IDLE and is ignored.
- rd = 0 still retires normally but never asserts `rf_wen`.
- STORE never asserts `rf_wen`.

## Timing
- Reset values of all outputs:
  - `in_ready` = 1.
  - `mem_req_valid`, `mem_wen`, `rf_wen`, `retire`, `misalign` = 0.
  - `mem_addr`, `mem_wdata`, `rf_wdata` = 0.
  - `mem_wmask` = 0.
  - `rf_waddr` = 0.
- Latencies from acceptance (cycle 0):
  - ALU: `rf_wen` in cycle 1.
  - Misaligned access: `retire`/`misalign` in cycle 1.
  - LOAD: `rf_wen` one cycle after the response cycle.
  - With a zero-wait memory (`mem_req_ready` high at REQ entry, response the next cycle): REQ in cycle 1, response in cycle 2, WB in cycle 3.
- Outputs:
  - All outputs are registered or decoded purely from state.
  - There is no combinational path from `mem_*` inputs to `rf_*` outputs.
- Throughput: one operation in flight; `in_ready` deasserts from the cycle after acceptance until IDLE.
- The register file samples `rf_*` on the same rising edge that leaves WB.

## Structure
- Package `npc_lsu_pkg` holds:
  - The kind enum (ALU/LOAD/STORE).
  - The funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - The state enum (IDLE, REQ, WAIT, WB).
- Sub-module `lsu_align` is purely combinational and holds:
  - Legality and alignment check.
  - Store mask and data formatting.
  - Load extraction and extension.
- The FSM, latch registers and output registers live in `lsu_wb`.

## Test plan
- ALU: in_kind = 0, rd = 5, result = 0x1234_5678 → cycle 1: `rf_wen` = 1, `rf_waddr` = 5, `rf_wdata` = 0x1234_5678, `retire` = 1.
- LB: addr = 0x8000_0003, mem_rdata = 0x80FF_0000, zero-wait memory → `mem_addr` = 0x8000_0000, `rf_wdata` = 0xFFFF_FF80; the LBU variant gives 0x0000_0080.
- SH: addr = 0x8000_0002, sdata = 0xDEAD_BEEF → `mem_wmask` = 1100, `mem_wdata` = 0xBEEF_BEEF, `rf_wen` stays 0, `retire` follows the response.
- LW at 0x8000_0002 → `misalign` and `retire` in cycle 1, no `mem_req_valid`, no `rf_wen`.
- LW with `mem_req_ready` held low for 3 cycles → `mem_req_valid` and `mem_addr` stay stable; `in_ready` = 0 throughout.
- Reset asserted in WAIT, then a late `mem_resp_valid` → stage is in IDLE with `in_ready` = 1, no `rf_wen`, no `retire`. Also check an ALU op with rd = 0 → `retire` = 1, `rf_wen` = 0.
